pattern_encoder: RTL and testbench

- Encodes a row-major-by-block stream of nonzero (row, col) coordinates into the team's sparse-pattern format.
- Produces two outputs: a 7-bit symbol stream for the downstream Huffman coder/writer, and an LSB-first packed argument bitstream in 64-bit words for the memory writer.
- Scan order inside a row block (SUBHEIGHT rows) is s = {col[INDEX_WIDTH-1:2], row[5:0], col[1:0]}, i.e. 64x4 tiles.
- It is the write-side producer of the stream that the pattern decoder consumes.

---
 rtl/pattern_encoder.sv | 171 +++++++++++++++++
 tb/tb_pattern_encoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_encoder.sv
// Sparse-pattern encoder: turns block-ordered (row, col) nonzeros into a 7-bit
// symbol stream plus an LSB-first packed argument bitstream of ARG_WIDTH words.
module pattern_encoder #(
    parameter int INDEX_WIDTH = 32,
    parameter int ARG_WIDTH   = 64,
    parameter int SUBHEIGHT   = 64,
    parameter int SUBWIDTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   index_valid,
    output logic                   index_ready,
    input  logic [INDEX_WIDTH-1:0] row,
    input  logic [INDEX_WIDTH-1:0] col,
    input  logic                   flush,
    output logic                   sym_valid,
    output logic [6:0]             sym,
    input  logic                   sym_stall,
    output logic                   arg_push,
    output logic [ARG_WIDTH-1:0]   arg_data,
    input  logic                   arg_stall,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            nnz_count
);
    localparam int RB = $clog2(SUBHEIGHT);
    localparam int CB = $clog2(SUBWIDTH);
    localparam int BW = INDEX_WIDTH - RB;
    localparam int SW = INDEX_WIDTH + RB;
    localparam int PW = SW + 1;
    localparam int AB = 2 * ARG_WIDTH;
    localparam int FW = $clog2(AB);

    typedef enum logic [2:0] {IDLE, NEWLINE, EMIT, FLUSH, DONE} state_t;
    state_t state, state_n;

    logic [RB-1:0]          row_lo;
    logic [INDEX_WIDTH-1:0] col_q;
    logic [BW-1:0]          blk_q, cur_block, blk_in;
    logic [PW-1:0]          prev_s, diff;
    logic [AB-1:0]          abuf, buf_pop;
    logic [FW-1:0]          fill, fill_pop;
    logic [SW-1:0]          s_cur;
    logic [4:0]             msb;
    logic [31:0]            arg_bits;
    logic [6:0]             sym_n;
    logic                   pending_flush, accept, bad, code2, pop;
    logic                   go_flush, nl_step, emit_ok, set_err, clr_blocks;

    assign blk_in      = row[INDEX_WIDTH-1:RB];
    assign index_ready = (state == IDLE) && !sym_stall && (fill < FW'(ARG_WIDTH)) && !pending_flush;
    assign accept      = index_valid && index_ready;

    // prev_s carries one extra bit so the -1 start value compares below s=0;
    // the top of diff is its sign, so a nonzero high part catches both
    // out-of-order input and deltas that do not fit 32 bits.
    assign s_cur = {col_q[INDEX_WIDTH-1:CB], row_lo, col_q[CB-1:0]};
    assign diff  = {1'b0, s_cur} - prev_s - PW'(1);
    assign bad   = diff[PW-1:32] != '0;
    assign code2 = diff[31:5] != '0;

    always_comb begin
        msb = '0;
        for (int i = 0; i < 32; i++)
            if (diff[i]) msb = 5'(i);
    end

    assign arg_bits = diff[31:0] & ~(32'hFFFF_FFFF << msb);
    assign sym_n    = code2 ? {msb, 2'd2} : {diff[4:0], 2'd1};

    // A partial word is only pushed while flushing; bits above fill are always zero.
    assign arg_push = (fill >= FW'(ARG_WIDTH)) || (state == FLUSH && fill != '0);
    assign arg_data = abuf[ARG_WIDTH-1:0];
    assign pop      = arg_push && !arg_stall;
    assign fill_pop = !pop ? fill : (fill >= FW'(ARG_WIDTH)) ? fill - FW'(ARG_WIDTH) : '0;
    assign buf_pop  = pop ? (abuf >> ARG_WIDTH) : abuf;
    assign done     = (state == DONE);

    always_comb begin
        state_n    = state;
        go_flush   = 1'b0;
        nl_step    = 1'b0;
        emit_ok    = 1'b0;
        set_err    = 1'b0;
        clr_blocks = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (blk_in > cur_block)       state_n = NEWLINE;
                    else if (blk_in == cur_block) state_n = EMIT;
                    else                          set_err = 1'b1;
                end else if (pending_flush && !sym_valid) begin
                    go_flush = 1'b1;
                    state_n  = FLUSH;
                end
            end
            NEWLINE: begin
                if (!sym_stall) begin
                    nl_step = 1'b1;
                    if (cur_block + BW'(1) == blk_q) state_n = EMIT;
                end
            end
            EMIT: begin
                if (bad) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else if (!sym_stall) begin
                    emit_ok = 1'b1;
                    state_n = IDLE;
                end
            end
            FLUSH: if (fill == '0) state_n = DONE;
            DONE: begin
                clr_blocks = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            row_lo        <= '0;
            col_q         <= '0;
            blk_q         <= '0;
            cur_block     <= '0;
            prev_s        <= '1;
            abuf          <= '0;
            fill          <= '0;
            pending_flush <= 1'b0;
            sym_valid     <= 1'b0;
            sym           <= '0;
            error         <= 1'b0;
            nnz_count     <= '0;
        end else begin
            state         <= state_n;
            pending_flush <= (pending_flush && !go_flush) || flush;
            if (accept) begin
                row_lo <= row[RB-1:0];
                col_q  <= col;
                blk_q  <= blk_in;
            end
            if (sym_valid && !sym_stall) sym_valid <= 1'b0;
            if (nl_step) begin
                sym_valid <= 1'b1;
                sym       <= '0;
                cur_block <= cur_block + BW'(1);
                prev_s    <= '1;
            end
            if (emit_ok) begin
                sym_valid <= 1'b1;
                sym       <= sym_n;
                prev_s    <= {1'b0, s_cur};
                nnz_count <= nnz_count + 32'd1;
            end
            if (set_err) error <= 1'b1;
            if (clr_blocks) begin
                cur_block <= '0;
                prev_s    <= '1;
            end
            if (emit_ok && code2) begin
                abuf <= buf_pop | ({{(AB-32){1'b0}}, arg_bits} << fill_pop);
                fill <= fill_pop + FW'(msb);
            end else begin
                abuf <= buf_pop;
                fill <= fill_pop;
            end
        end
    end
endmodule

// File: tb/tb_pattern_encoder.sv
// Directed bench for pattern_encoder: table of single-coordinate vectors plus
// hand-written sequences for backpressure, word packing, ordering errors and reset.
module tb_pattern_encoder;
    logic        clk = 0, rst = 1, index_valid = 0, flush = 0, sym_stall = 0, arg_stall = 0;
    logic [31:0] row = 0, col = 0;
    logic        index_ready, sym_valid, arg_push, done, error;
    logic [6:0]  sym;
    logic [63:0] arg_data;
    logic [31:0] nnz_count;

    int          n_cmp = 0, n_fail = 0;
    logic [6:0]  symq[$];
    logic [63:0] argq[$];
    bit          stop_tog;

    typedef struct {
        logic [31:0] row;
        logic [31:0] col;
        int          nl;
        logic [6:0]  sym;
        logic [31:0] nnz;
        bit          do_flush;
        logic [63:0] word;
    } vec_t;
    vec_t vecs[6];

    pattern_encoder dut (
        .clk(clk), .rst(rst), .index_valid(index_valid), .index_ready(index_ready),
        .row(row), .col(col), .flush(flush), .sym_valid(sym_valid), .sym(sym),
        .sym_stall(sym_stall), .arg_push(arg_push), .arg_data(arg_data),
        .arg_stall(arg_stall), .done(done), .error(error), .nnz_count(nnz_count)
    );

    always #5 clk = ~clk;

    // Handshakes complete at the next rising edge; inputs change only just after rising edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (sym_valid && !sym_stall) symq.push_back(sym);
            if (arg_push && !arg_stall) argq.push_back(arg_data);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] c);
        int t = 0;
        index_valid = 1;
        row = r;
        col = c;
        @(negedge clk);
        while (!index_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("send_accepted", 64'(index_ready), 64'd1);
        tick();
        index_valid = 0;
    endtask

    task automatic wait_syms(input int n);
        int t = 0;
        while (symq.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (symq.size() < n) check("sym_timeout", 64'(symq.size()), 64'(n));
    endtask

    task automatic do_flush();
        int t = 0;
        bit seen = 0;
        flush = 1;
        tick();
        flush = 0;
        while (!seen && t < 400) begin
            @(negedge clk);
            if (done) seen = 1;
            t++;
        end
        check("done_pulse", 64'(seen), 64'd1);
        tick();
    endtask

    initial begin
        logic [319:0] refbits;
        logic [31:0]  d;
        logic [37:0]  sv;
        longint       s;
        int           pos;

        vecs[0] = '{32'd0,   32'd0, 0, 7'h01, 32'd1, 1'b0, 64'h0};
        vecs[1] = '{32'd0,   32'd1, 0, 7'h01, 32'd2, 1'b0, 64'h0};
        vecs[2] = '{32'd0,   32'd4, 0, 7'h1E, 32'd3, 1'b1, 64'h7E};
        vecs[3] = '{32'd3,   32'd0, 0, 7'h31, 32'd4, 1'b0, 64'h0};
        vecs[4] = '{32'd64,  32'd0, 1, 7'h01, 32'd5, 1'b0, 64'h0};
        vecs[5] = '{32'd200, 32'd1, 2, 7'h16, 32'd6, 1'b1, 64'h01};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_outputs", {59'd0, sym_valid, arg_push, done, error, index_ready}, 64'h1);
        check("reset_nnz", 64'(nnz_count), 64'd0);
        tick();

        // Basic deltas, long delta with argument bits, newlines, flush words.
        for (int i = 0; i < 6; i++) begin
            symq.delete();
            send(vecs[i].row, vecs[i].col);
            wait_syms(vecs[i].nl + 1);
            repeat (3) @(negedge clk);
            check("vec_symcount", 64'(symq.size()), 64'(vecs[i].nl + 1));
            for (int j = 0; j < symq.size(); j++)
                check("vec_sym", 64'(symq[j]), (j < vecs[i].nl) ? 64'h0 : 64'(vecs[i].sym));
            check("vec_nnz", 64'(nnz_count), 64'(vecs[i].nnz));
            tick();
            if (vecs[i].do_flush) begin
                do_flush();
                check("flush_wordcount", 64'(argq.size()), 64'd1);
                if (argq.size() > 0) check("flush_word", argq[0], vecs[i].word);
                argq.delete();
            end
        end
        check("no_error", 64'(error), 64'd0);

        // Symbol backpressure in the middle of a four-newline burst.
        symq.delete();
        send(32'd256, 32'd0);
        tick();
        sym_stall = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_hold", {55'd0, sym_valid, sym, index_ready}, {55'd0, 1'b1, 7'h00, 1'b0});
            tick();
        end
        sym_stall = 0;
        wait_syms(5);
        repeat (4) @(negedge clk);
        check("stall_symcount", 64'(symq.size()), 64'd5);
        for (int j = 0; j < symq.size(); j++)
            check("stall_sym", 64'(symq[j]), (j < 4) ? 64'h0 : 64'h01);
        check("stall_nnz", 64'(nnz_count), 64'd7);
        tick();
        do_flush();
        check("empty_flush", 64'(argq.size()), 64'd0);

        // Ten 31-bit arguments packed across words with a toggling arg_stall.
        symq.delete();
        argq.delete();
        refbits = '0;
        pos = 0;
        s = -1;
        stop_tog = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    d = 32'h8000_0000 | (32'h1357_9BDF * 32'(k + 1));
                    for (int b = 0; b < 31; b++) refbits[pos + b] = d[b];
                    pos += 31;
                    s = s + longint'(d) + 1;
                    sv = s[37:0];
                    send({26'd0, sv[7:2]}, {sv[37:8], sv[1:0]});
                end
                wait_syms(10);
                tick();
                do_flush();
                stop_tog = 1;
            end
            begin
                while (!stop_tog) begin
                    tick();
                    arg_stall = ~arg_stall;
                end
                arg_stall = 0;
            end
        join
        check("pack_symcount", 64'(symq.size()), 64'd10);
        for (int j = 0; j < symq.size(); j++) check("pack_sym", 64'(symq[j]), 64'h7E);
        check("pack_wordcount", 64'(argq.size()), 64'd5);
        for (int j = 0; j < 5 && j < argq.size(); j++) check("pack_word", argq[j], refbits[j*64 +: 64]);
        check("pack_nnz", 64'(nnz_count), 64'd17);

        // Out-of-order coordinate is dropped and flags the sticky error.
        symq.delete();
        send(32'd0, 32'd5);
        send(32'd0, 32'd1);
        repeat (5) @(negedge clk);
        check("order_error", 64'(error), 64'd1);
        check("order_nnz", 64'(nnz_count), 64'd18);
        check("order_symcount", 64'(symq.size()), 64'd1);
        if (symq.size() > 0) check("order_sym", 64'(symq[0]), 64'h22);
        tick();

        // Reset in the middle of a newline burst discards everything.
        send(32'd128, 32'd0);
        tick();
        rst = 1;
        tick();
        rst = 0;
        symq.delete();
        @(negedge clk);
        check("midrst_outputs", {59'd0, sym_valid, arg_push, done, error, index_ready}, 64'h1);
        check("midrst_nnz", 64'(nnz_count), 64'd0);
        repeat (10) @(negedge clk);
        check("midrst_quiet", 64'(symq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
